// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int LINE_BYTES = 16;
    localparam int NUM_LINES  = 16;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = 32 - OFF_W - IDX_W;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WSEL_W     = OFF_W - 2;
    localparam int LINE_WORDS = LINE_BYTES / 4;

    typedef logic [31:0]       addr_t;
    typedef logic [31:0]       word_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [WSEL_W-1:0] wsel_t;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_e;

    function automatic word_t line_word(
        input line_t line,
        input wsel_t sel
    );
        word_t w;
        w = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (sel == k[WSEL_W-1:0]) begin
                w = line[k*32 +: 32];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    logic  fetch_valid;
    addr_t fetch_pc;
    logic  inst_valid;
    word_t inst;
    addr_t inst_pc;
    logic  busy;
    logic  mem_find_valid;
    addr_t mem_find_addr;
    logic  mem_data_valid;
    line_t mem_data;

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  mem_data_valid,
        input  mem_data,
        output inst_valid,
        output inst,
        output inst_pc,
        output busy,
        output mem_find_valid,
        output mem_find_addr
    );

    modport master (
        output fetch_valid,
        output fetch_pc,
        output mem_data_valid,
        output mem_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  busy,
        input  mem_find_valid,
        input  mem_find_addr
    );

endinterface

// File: rtl/icache_line_ram.sv
// Tag + line storage: one synchronous write port, one async read port.
module icache_line_ram
    import icache_pkg::*;
(
    input  logic  clk,
    input  logic  we_i,
    input  idx_t  waddr_i,
    input  tag_t  wtag_i,
    input  line_t wdata_i,
    input  idx_t  raddr_i,
    output tag_t  rtag_o,
    output line_t rdata_o
);

    tag_t  tag_q  [NUM_LINES];
    line_t data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[waddr_i]  <= wtag_i;
            data_q[waddr_i] <= wdata_i;
        end
    end

    assign rtag_o  = tag_q[raddr_i];
    assign rdata_o = data_q[raddr_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
module icache
    import icache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rollback,
    icache_if.slave bus
);

    state_e                 state_q;
    logic [NUM_LINES-1:0]   valid_q;
    addr_t                  pc_q;
    logic                   inst_valid_q;
    word_t                  inst_q;
    addr_t                  inst_pc_q;
    logic                   busy_q;
    logic                   find_valid_q;
    addr_t                  find_addr_q;

    idx_t  f_idx;
    tag_t  f_tag;
    wsel_t f_wsel;
    idx_t  r_idx;
    tag_t  r_tag;
    wsel_t r_wsel;
    tag_t  rd_tag;
    line_t rd_line;
    logic  hit;
    logic  fill;

    assign f_idx  = bus.fetch_pc[OFF_W+IDX_W-1:OFF_W];
    assign f_tag  = bus.fetch_pc[31:OFF_W+IDX_W];
    assign f_wsel = bus.fetch_pc[OFF_W-1:2];
    assign r_idx  = pc_q[OFF_W+IDX_W-1:OFF_W];
    assign r_tag  = pc_q[31:OFF_W+IDX_W];
    assign r_wsel = pc_q[OFF_W-1:2];

    assign hit = valid_q[f_idx] && (rd_tag == f_tag);

    // Returning data is trusted even under rollback; only IDLE drops it.
    assign fill = rdy && (state_q == S_REFILL)
                && bus.mem_data_valid;

    icache_line_ram u_ram (
        .clk     (clk),
        .we_i    (fill),
        .waddr_i (r_idx),
        .wtag_i  (r_tag),
        .wdata_i (bus.mem_data),
        .raddr_i (f_idx),
        .rtag_o  (rd_tag),
        .rdata_o (rd_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            pc_q         <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            busy_q       <= 1'b0;
            find_valid_q <= 1'b0;
            find_addr_q  <= '0;
        end else if (rdy) begin
            inst_valid_q <= 1'b0;
            if (fill) begin
                valid_q[r_idx] <= 1'b1;
            end
            if (rollback) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                find_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.fetch_valid && hit) begin
                            inst_valid_q <= 1'b1;
                            inst_q       <= line_word(rd_line, f_wsel);
                            inst_pc_q    <= bus.fetch_pc;
                        end else if (bus.fetch_valid) begin
                            pc_q         <= bus.fetch_pc;
                            state_q      <= S_REFILL;
                            busy_q       <= 1'b1;
                            find_valid_q <= 1'b1;
                            find_addr_q  <= {f_tag, f_idx,
                                             {OFF_W{1'b0}}};
                        end
                    end
                    S_REFILL: begin
                        if (bus.mem_data_valid) begin
                            inst_valid_q <= 1'b1;
                            inst_q       <= line_word(bus.mem_data,
                                                      r_wsel);
                            inst_pc_q    <= pc_q;
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                            find_valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.busy           = busy_q;
    assign bus.mem_find_valid = find_valid_q;
    assign bus.mem_find_addr  = find_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench: the bench plays IFetch and MemCtrl and keeps
// a residency model of which line occupies each cache set.
module tb_icache;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    icache_if bus ();

    icache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int unsigned m_tag [NUM_LINES];
    bit          m_v   [NUM_LINES];

    task automatic check(string tag, logic [31:0] obs,
                         logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Backing memory contents, addressed by aligned word address.
    function automatic word_t mem_word(addr_t a);
        word_t w;
        case (a)
            32'h0:   w = 32'h0000_0013;
            32'h4:   w = 32'hBBAA_9988;
            32'h8:   w = 32'h7766_5544;
            32'hC:   w = 32'h3322_1100;
            default: w = (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
        return w;
    endfunction

    function automatic line_t mem_line(addr_t base);
        line_t l;
        l = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            l[k*32 +: 32] = mem_word(base + 32'(4 * k));
        end
        return l;
    endfunction

    function automatic int set_of(addr_t pc);
        return int'((pc / LINE_BYTES) % NUM_LINES);
    endfunction

    function automatic int unsigned tag_of(addr_t pc);
        return pc / (LINE_BYTES * NUM_LINES);
    endfunction

    function automatic addr_t base_of(addr_t pc);
        return pc - (pc % LINE_BYTES);
    endfunction

    function automatic bit resident(addr_t pc);
        return m_v[set_of(pc)] && (m_tag[set_of(pc)] == tag_of(pc));
    endfunction

    task automatic install(addr_t pc);
        m_v[set_of(pc)]   = 1'b1;
        m_tag[set_of(pc)] = tag_of(pc);
    endtask

    task automatic flush_model();
        for (int i = 0; i < NUM_LINES; i++) m_v[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(addr_t pc, output bit was_hit);
        was_hit = resident(pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        tick();
        bus.fetch_valid = 1'b0;
        if (was_hit) begin
            check("hit_v", 32'(bus.inst_valid), 1);
            check("hit_inst", bus.inst, mem_word(pc & ~32'h3));
            check("hit_pc", bus.inst_pc, pc);
            check("hit_find", 32'(bus.mem_find_valid), 0);
        end else begin
            check("miss_v", 32'(bus.inst_valid), 0);
            check("miss_busy", 32'(bus.busy), 1);
            check("miss_find", 32'(bus.mem_find_valid), 1);
            check("miss_addr", bus.mem_find_addr, base_of(pc));
        end
    endtask

    task automatic serve(addr_t pc, int lat);
        repeat (lat) begin
            tick();
            check("wait_find", 32'(bus.mem_find_valid), 1);
            check("wait_v", 32'(bus.inst_valid), 0);
        end
        bus.mem_data_valid = 1'b1;
        bus.mem_data       = mem_line(base_of(pc));
        tick();
        bus.mem_data_valid = 1'b0;
        check("fill_v", 32'(bus.inst_valid), 1);
        check("fill_inst", bus.inst, mem_word(pc & ~32'h3));
        check("fill_pc", bus.inst_pc, pc);
        check("fill_busy", 32'(bus.busy), 0);
        check("fill_find", 32'(bus.mem_find_valid), 0);
        install(pc);
    endtask

    task automatic access(addr_t pc, int lat);
        bit h;
        do_fetch(pc, h);
        if (!h) serve(pc, lat);
    endtask

    task automatic abort(addr_t pc, int lat, bit with_data);
        bit h;
        do_fetch(pc, h);
        if (h) return;
        repeat (lat) tick();
        rollback           = 1'b1;
        bus.mem_data_valid = with_data;
        bus.mem_data       = mem_line(base_of(pc));
        tick();
        rollback           = 1'b0;
        bus.mem_data_valid = 1'b0;
        check("rb_v", 32'(bus.inst_valid), 0);
        check("rb_busy", 32'(bus.busy), 0);
        check("rb_find", 32'(bus.mem_find_valid), 0);
        if (with_data) begin
            install(pc);
        end else begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = ~mem_line(base_of(pc));
            tick();
            bus.mem_data_valid = 1'b0;
            check("stale_v", 32'(bus.inst_valid), 0);
        end
    endtask

    task automatic rb_fetch(addr_t pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        rollback        = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        rollback        = 1'b0;
        check("rbf_v", 32'(bus.inst_valid), 0);
        check("rbf_busy", 32'(bus.busy), 0);
        check("rbf_find", 32'(bus.mem_find_valid), 0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_v"}, 32'(bus.inst_valid), 0);
        check({tag, "_inst"}, bus.inst, 0);
        check({tag, "_pc"}, bus.inst_pc, 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_find"}, 32'(bus.mem_find_valid), 0);
        check({tag, "_addr"}, bus.mem_find_addr, 0);
    endtask

    initial begin
        bit    h;
        addr_t pc;
        int    op;

        rst                = 1'b1;
        rdy                = 1'b1;
        rollback           = 1'b0;
        bus.fetch_valid    = 1'b0;
        bus.fetch_pc       = '0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data       = '0;
        flush_model();

        #3;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_zero("post_rst");

        access(32'h0, 0);
        access(32'h4, 0);
        access(32'h8, 0);
        access(32'hC, 0);
        tick();
        check("idle_v", 32'(bus.inst_valid), 0);

        access(32'h100, 1);
        access(32'h0, 2);
        access(32'h104, 0);

        abort(32'h40, 1, 1'b0);
        access(32'h40, 0);
        abort(32'h80, 0, 1'b1);
        access(32'h80, 0);
        rb_fetch(32'h0);

        do_fetch(32'h200, h);
        rdy = 1'b0;
        repeat (5) begin
            tick();
            check("frz_busy", 32'(bus.busy), 1);
            check("frz_find", 32'(bus.mem_find_valid), 1);
            check("frz_addr", bus.mem_find_addr, 32'h200);
            check("frz_v", 32'(bus.inst_valid), 0);
        end
        rdy = 1'b1;
        serve(32'h200, 0);
        access(32'h204, 0);
        rdy = 1'b0;
        tick();
        check("frz_hold_v", 32'(bus.inst_valid), 1);
        check("frz_hold_pc", bus.inst_pc, 32'h204);
        rdy = 1'b1;
        tick();
        check("frz_rel_v", 32'(bus.inst_valid), 0);

        do_fetch(32'h300, h);
        #2;
        rst = 1'b1;
        #1;
        check("arst_v", 32'(bus.inst_valid), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_find", 32'(bus.mem_find_valid), 0);
        check("arst_addr", bus.mem_find_addr, 0);
        rst = 1'b0;
        flush_model();
        tick();
        access(32'h0, 1);

        for (int i = 0; i < 400; i++) begin
            pc = (32'($urandom_range(0, 3)) << 8)
               | (32'($urandom_range(0, 15)) << 4)
               | (32'($urandom_range(0, 3)) << 2)
               | 32'($urandom_range(0, 3));
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                abort(pc, int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)));
            end else if (op == 1) begin
                rb_fetch(pc);
            end else if (op == 2) begin
                tick();
                check("rnd_idle_v", 32'(bus.inst_valid), 0);
            end else begin
                access(pc, int'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
